qam16_demapper: RTL and testbench



---
 rtl/qam16_demapper.sv | 148 ++++++++++++++
 tb/tb_qam16_demapper.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_demapper.sv
// Hard-decision 16-QAM slicer: N parallel signed I/Q samples in, N 4-bit symbols out, with a frame-start flag.
// Latency: 2 cycles from input transfer to out_valid (S1 sample register, S2 decision register); one block per cycle.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready (no skid buffer), and a stalled S2 holds S1.
module qam16_demapper #(
  parameter int                   N         = 16,
  parameter int                   W         = 16,
  parameter logic signed [W-1:0]  AMP       = 16'sd4096,
  parameter int                   FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W*N-1:0]   in_I,
  input  logic [W*N-1:0]   in_Q,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [4*N-1:0]   out_sym,
  output logic [W-1:0]     out_last,
  output logic             out_sof,
  output logic             out_valid,
  input  logic             out_ready
);

  // Counter is at least one bit wide so FRAME_LEN=1 still elaborates cleanly.
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Ideal constellation levels; 3*AMP is assumed to fit in W bits.
  localparam logic signed [W-1:0] LVL_P1 = AMP;
  localparam logic signed [W-1:0] LVL_P3 = AMP + AMP + AMP;
  localparam logic signed [W-1:0] LVL_M1 = -AMP;
  localparam logic signed [W-1:0] LVL_M3 = -(AMP + AMP + AMP);

  // Decision threshold 2*AMP held in W+1 bits so -T and T never overflow.
  localparam logic signed [W:0] THR = $signed({AMP, 1'b0});

  // Per-axis slicer. Code map: 00=-3A, 01=-A, 11=+A, 10=+3A (Gray order).
  // Ties: 0 -> 11, +T -> 10, -T -> 01. Extremes cannot wrap because the
  // comparison is done on the sign-extended W+1 bit value.
  function automatic logic [1:0] slice(input logic signed [W-1:0] x);
    logic signed [W:0] xe;
    xe = {x[W-1], x};
    if (xe < -THR)
      slice = 2'b00;
    else if (x[W-1])
      slice = 2'b01;
    else if (xe < THR)
      slice = 2'b11;
    else
      slice = 2'b10;
  endfunction

  logic             r_s1_vld;
  logic [W*N-1:0]   r_s1_i;
  logic [W*N-1:0]   r_s1_q;

  logic             r_out_vld;
  logic [4*N-1:0]   r_out_sym;
  logic [W-1:0]     r_out_last;
  logic             r_out_sof;
  logic [CW-1:0]    r_blk_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_in_rdy;
  logic [4*N-1:0]   w_sym;
  logic [1:0]       w_last_code;
  logic [W-1:0]     w_last_lvl;

  // Handshake: S2 loads when it is empty or being drained; S1 accepts when it is empty or moving on.
  always_comb begin
    w_adv2   = r_s1_vld & (~r_out_vld | out_ready);
    w_in_rdy = ~r_s1_vld | w_adv2;
    w_adv1   = in_valid & w_in_rdy;
  end

  // Slice every lane of the S1 block and reconstruct the ideal I level of the last lane.
  always_comb begin
    w_sym       = '0;
    w_last_code = '0;
    w_last_lvl  = '0;
    for (int k = 0; k < N; k++) begin
      w_sym[4*k +: 4] = {slice(r_s1_i[W*k +: W]), slice(r_s1_q[W*k +: W])};
    end
    w_last_code = w_sym[4*N-1 -: 2];
    case (w_last_code)
      2'b00:   w_last_lvl = LVL_M3;
      2'b01:   w_last_lvl = LVL_M1;
      2'b11:   w_last_lvl = LVL_P1;
      default: w_last_lvl = LVL_P3;
    endcase
  end

  // Stage 1: capture raw samples on input transfer; empty out when S2 takes the block with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_i   <= '0;
      r_s1_q   <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_vld <= 1'b1;
        r_s1_i   <= in_I;
        r_s1_q   <= in_Q;
      end else if (w_adv2) begin
        r_s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2: register decisions, last-lane level and frame-start flag; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_sym  <= '0;
      r_out_last <= '0;
      r_out_sof  <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_out_vld  <= 1'b1;
        r_out_sym  <= w_sym;
        r_out_last <= w_last_lvl;
        r_out_sof  <= (r_blk_cnt == '0);
      end else if (out_ready) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  // Block counter: one step per S2 load, wrapping at the end of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (w_adv2) begin
      if (r_blk_cnt == CNT_LAST)
        r_blk_cnt <= '0;
      else
        r_blk_cnt <= r_blk_cnt + CNT_ONE;
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = r_out_vld;
  assign out_sym   = r_out_sym;
  assign out_last  = r_out_last;
  assign out_sof   = r_out_sof;

endmodule

// File: tb/tb_qam16_demapper.sv
// Directed bench for qam16_demapper: table of single-block vectors, hand-written stall and reset sequences,
// a continuous 130-block stream with frame-start checks, and a noisy random stream against transmitted symbols.
module tb_qam16_demapper;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int A  = 4096;

  logic             clk;
  logic             rst_n;
  logic [W*N-1:0]   in_I;
  logic [W*N-1:0]   in_Q;
  logic             in_valid;
  logic             in_ready;
  logic [4*N-1:0]   out_sym;
  logic [W-1:0]     out_last;
  logic             out_sof;
  logic             out_valid;
  logic             out_ready;

  logic             u1_in_ready;
  logic [4*N-1:0]   u1_out_sym;
  logic [W-1:0]     u1_out_last;
  logic             u1_out_sof;
  logic             u1_out_valid;

  int checks;
  int failures;

  qam16_demapper #(.N(N), .W(W), .AMP(16'sd4096), .FRAME_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_I(in_I), .in_Q(in_Q), .in_valid(in_valid),
    .in_ready(in_ready), .out_sym(out_sym), .out_last(out_last), .out_sof(out_sof),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Second instance with one-block frames, driven in lockstep.
  qam16_demapper #(.N(N), .W(W), .AMP(16'sd4096), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_I(in_I), .in_Q(in_Q), .in_valid(in_valid),
    .in_ready(u1_in_ready), .out_sym(u1_out_sym), .out_last(u1_out_last), .out_sof(u1_out_sof),
    .out_valid(u1_out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference slicer, written directly from the decision regions.
  function automatic logic [1:0] ref_slice(input int x);
    if (x < -2*A)      return 2'b00;
    else if (x < 0)    return 2'b01;
    else if (x < 2*A)  return 2'b11;
    else               return 2'b10;
  endfunction

  function automatic int ref_level(input logic [1:0] c);
    case (c)
      2'b00:   return -3*A;
      2'b01:   return -A;
      2'b11:   return A;
      default: return 3*A;
    endcase
  endfunction

  function automatic logic [W*N-1:0] rep(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {N{t}};
  endfunction

  typedef struct {
    logic [W*N-1:0] i;
    logic [W*N-1:0] q;
    logic [4*N-1:0] sym;
    logic [W-1:0]   last;
  } vec_t;

  function automatic vec_t uni(input int vi, input int vq, input logic [3:0] nib, input int lvl);
    vec_t v;
    v.i    = rep(vi);
    v.q    = rep(vq);
    v.sym  = {N{nib}};
    v.last = lvl[15:0];
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Send one block into an idle pipeline and compare the emerging block.
  task automatic send_one(input string nm, input vec_t v);
    int n;
    in_I = v.i; in_Q = v.q; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      failures++; checks++;
      $display("FAIL %s_timeout: got no out_valid expected out_valid within 8 cycles", nm);
    end else begin
      chk({nm, "_sym"}, out_sym, v.sym);
      chk({nm, "_last"}, out_last, v.last);
    end
    @(posedge clk); #1;
  endtask

  int pool[12] = '{-32768, -12289, -8193, -8192, -4096, -1, 0, 1, 4096, 8191, 8192, 32767};

  // Build block number idx. Noisy blocks pick ideal points plus bounded noise and
  // expect the transmitted nibbles; otherwise cycle through boundary values.
  task automatic gen_block(input int idx, input bit noisy,
                           output logic [W*N-1:0] bi, output logic [W*N-1:0] bq,
                           output logic [4*N-1:0] bs, output logic [W-1:0] bl);
    int xi, xq, lv;
    logic [1:0] ci, cq;
    for (int k = 0; k < N; k++) begin
      if (noisy) begin
        ci = 2'($urandom_range(0, 3));
        cq = 2'($urandom_range(0, 3));
        xi = ref_level(ci) + int'($urandom_range(0, 2730)) - 1365;
        xq = ref_level(cq) + int'($urandom_range(0, 2730)) - 1365;
      end else begin
        xi = pool[(idx*5 + k*3) % 12];
        xq = pool[(idx*7 + k + 1) % 12];
        ci = ref_slice(xi);
        cq = ref_slice(xq);
      end
      bi[16*k +: 16] = xi[15:0];
      bq[16*k +: 16] = xq[15:0];
      bs[4*k +: 4]   = {ci, cq};
      if (k == N-1) begin
        lv = ref_level(ci);
        bl = lv[15:0];
      end
    end
  endtask

  // Streaming scoreboard. Handshakes are sampled at the falling edge; inputs change just after the rising edge.
  task automatic run_stream(input string nm, input int nblk, input bit noisy);
    logic [4*N-1:0] qs[$];
    logic [W-1:0]   ql[$];
    logic [W*N-1:0] ci, cq;
    logic [4*N-1:0] cs, es;
    logic [W-1:0]   cl, el;
    int sent, rcvd, cyc, first_c, last_c, limit;
    bit fi, fo;
    sent = 0; rcvd = 0; cyc = 0; first_c = -1; last_c = -1;
    limit = nblk * 8 + 50;
    gen_block(0, noisy, ci, cq, cs, cl);
    in_I = ci; in_Q = cq; in_valid = 1'b1; out_ready = 1'b1;
    while (rcvd < nblk && cyc < limit) begin
      @(negedge clk);
      fo = out_valid && out_ready;
      fi = in_valid && in_ready;
      if (fo) begin
        if (qs.size() == 0) begin
          failures++; checks++;
          $display("FAIL %s_extra: got unexpected block expected none at output %0d", nm, rcvd);
        end else begin
          es = qs.pop_front();
          el = ql.pop_front();
          chk({nm, "_sym"}, out_sym, es);
          chk({nm, "_last"}, out_last, el);
          if (!noisy) begin
            chk({nm, "_sof"}, out_sof, (rcvd % 64) == 0);
            chk({nm, "_sof_len1"}, u1_out_sof & u1_out_valid, 1);
          end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        rcvd++;
      end
      if (fi) begin
        qs.push_back(cs);
        ql.push_back(cl);
        sent++;
        if (sent < nblk) gen_block(sent, noisy, ci, cq, cs, cl);
      end
      @(posedge clk); #1;
      cyc++;
      in_I = ci; in_Q = cq;
      in_valid  = (sent < nblk) && (noisy ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({nm, "_count"}, rcvd, nblk);
    if (!noisy) chk({nm, "_rate"}, last_c - first_c, nblk - 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({nm, "_drained"}, out_valid, 0);
  endtask

  vec_t tbl[11];
  vec_t mix;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_I = '0; in_Q = '0;

    // Vector table: uniform blocks; expected nibble {I code, Q code} and last-lane I level.
    tbl[0]  = uni( 3*A,   -A,     4'b1001,  3*A);
    tbl[1]  = uni( 0,     -2*A,   4'b1101,  A);
    tbl[2]  = uni( 2*A,   -1,     4'b1001,  3*A);
    tbl[3]  = uni(-32768, 32767,  4'b0010, -3*A);
    tbl[4]  = uni(-8193,  8191,   4'b0011, -3*A);
    tbl[5]  = uni(-1,     -8192,  4'b0101, -A);
    tbl[6]  = uni( A,      A,     4'b1111,  A);
    tbl[7]  = uni(-3*A,    3*A,   4'b0010, -3*A);
    tbl[8]  = uni(-A,      0,     4'b0111, -A);
    tbl[9]  = uni( 8191,  -8193,  4'b1100,  A);
    tbl[10] = uni( 8192,   8192,  4'b1010,  3*A);

    // Mixed lanes: lane0 (0,-2A), lane1 (2A,-1), lane2 (-32768,32767), rest (A,A).
    mix = uni(A, A, 4'b1111, A);
    mix.i[15:0]  = 16'h0000; mix.q[15:0]  = 16'hE000;
    mix.i[31:16] = 16'h2000; mix.q[31:16] = 16'hFFFF;
    mix.i[47:32] = 16'h8000; mix.q[47:32] = 16'h7FFF;
    mix.sym = 64'hFFFF_FFFF_FFFF_F29D;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sof", out_sof, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First block: exact 2-cycle latency, frame start flagged, then drain.
    in_I = tbl[0].i; in_Q = tbl[0].q; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("first_valid", out_valid, 1);
    chk("first_sym", out_sym, {N{4'b1001}});
    chk("first_last", out_last, 16'h3000);
    chk("first_sof", out_sof, 1);
    @(posedge clk); #1;
    chk("first_drain", out_valid, 0);

    for (int v = 0; v < 11; v++) send_one($sformatf("tbl%0d", v), tbl[v]);
    send_one("mixed", mix);

    // Stall: two blocks buffered, in_ready low, outputs hold, then both emerge in order.
    do_reset();
    out_ready = 1'b0;
    in_I = rep(3*A); in_Q = rep(-A); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_rdy_one_buffered", in_ready, 1);
    in_I = rep(-A); in_Q = rep(3*A);
    @(posedge clk); #1;
    in_I = rep(0); in_Q = rep(0);
    for (int c = 0; c < 4; c++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sym_hold", out_sym, {N{4'h9}});
      chk("stall_last_hold", out_last, 16'h3000);
      chk("stall_sof_hold", out_sof, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_b_sym", out_sym, {N{4'h6}});
    chk("release_b_last", out_last, 16'hF000);
    chk("release_b_sof", out_sof, 0);
    @(posedge clk); #1;
    chk("release_c_valid", out_valid, 1);
    chk("release_c_sym", out_sym, {N{4'hF}});
    @(posedge clk); #1;
    chk("release_drain", out_valid, 0);

    // Asynchronous reset with two blocks in flight.
    out_ready = 1'b1;
    in_I = rep(A); in_Q = rep(A); in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_sym", out_sym, 0);
    chk("arst_out_sof", out_sof, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_ghost", out_valid, 0);
    in_I = rep(-3*A); in_Q = rep(-A); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("arst_ghost2", out_valid, 0);
    @(posedge clk); #1;
    chk("arst_new_valid", out_valid, 1);
    chk("arst_new_sym", out_sym, {N{4'b0001}});
    chk("arst_new_sof", out_sof, 1);
    @(posedge clk); #1;

    // Continuous stream: frame starts on blocks 0, 64 and 128.
    do_reset();
    run_stream("stream", 130, 1'b0);

    // Noisy constellation with random valid/ready gaps.
    do_reset();
    run_stream("noisy", 10000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
